quad_step_decoder: RTL

QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

---
 rtl/quad_step_decoder.sv | 91 +++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: filtered quadrature/index decoder driving step/up/load for a downstream counter; define QUAD_ERR_CNT_EN to enable the saturating err_cnt.
module quad_step_decoder #(
  parameter int BITS = 4,
  parameter int FILT_LEN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enc_a,
  input  logic            enc_b,
  input  logic            enc_idx,
  input  logic [BITS-1:0] home_val,
  output logic            step,
  output logic            up,
  output logic            load,
  output logic [BITS-1:0] PI,
  output logic            err,
  output logic [7:0]      err_cnt
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [2:0] s1, s2, filt;
  logic [2:0][2:0] fcnt;
  logic [1:0] ref_ab, pos_new, pos_old, delta;
  logic idx_prev, rise;
  logic [3:0] init_cnt;
  // Gray {A,B} mapped to a 2-bit position so the direction is just the position difference
  always_comb begin
    pos_new = {filt[1], filt[1] ^ filt[0]};
    pos_old = {ref_ab[1], ref_ab[1] ^ ref_ab[0]};
    delta = pos_new - pos_old;
    rise = filt[2] & ~idx_prev;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      fcnt <= '0;
      ref_ab <= '0;
      idx_prev <= 1'b0;
      init_cnt <= '0;
      step <= 1'b0;
      up <= 1'b0;
      load <= 1'b0;
      PI <= '0;
      err <= 1'b0;
    end else begin
      s1 <= {enc_idx, enc_a, enc_b};
      s2 <= s1;
      // counts consecutive samples that disagree with the held level
      for (int i = 0; i < 3; i++)
        if (s2[i] == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == 3'(FILT_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + 3'd1;
      step <= 1'b0;
      load <= 1'b0;
      PI <= '0;
      err <= 1'b0;
      if (state == INIT) begin
        init_cnt <= init_cnt + 4'd1;
        if (init_cnt == 4'(2 + FILT_LEN)) begin
          ref_ab <= filt[1:0];
          idx_prev <= filt[2];
          state <= RUN;
        end
      end else begin
        ref_ab <= filt[1:0];
        idx_prev <= filt[2];
        if (rise) begin
          load <= 1'b1;
          PI <= home_val;
        end
        if (delta == 2'd2) err <= 1'b1;
        else if (delta != 2'd0 && !rise) begin
          step <= 1'b1;
          up <= (delta == 2'd1);
        end
      end
    end
  end
`ifdef QUAD_ERR_CNT_EN
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (state == RUN && delta == 2'd2 && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
`else
  assign err_cnt = '0;
`endif
endmodule
